// File: rtl/beat_gen_if.sv
// ============================================================================
// Module   : beat_gen_if
// Brief    : Control/strobe bundle between a tempo master and beat_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface beat_gen_if #(
    parameter int PW    = 22,
    parameter int BEATS = 4
);
    localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic          en;
    logic          sync;
    logic          oneshot;
    logic [PW-1:0] period;
    logic          beat;
    logic          bar;
    logic [IW-1:0] beat_idx;
    logic          done;

    modport master (
        output en, sync, oneshot, period,
        input  beat, bar, beat_idx, done
    );

    modport slave (
        input  en, sync, oneshot, period,
        output beat, bar, beat_idx, done
    );
endinterface

`default_nettype wire

// File: rtl/beat_gen.sv
// ============================================================================
// Module   : beat_gen
// Brief    : Programmable-period beat/bar strobe generator with pause,
//            synchronous restart and single-bar one-shot mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_gen #(
    parameter int PW    = 22,
    parameter int BEATS = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    beat_gen_if.slave  bus
);
    localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [IW-1:0] c_last    = IW'(BEATS - 1);
    localparam logic [IW-1:0] c_idx_one = (BEATS > 1) ? IW'(1) : '0;
    localparam logic [PW-1:0] c_one     = PW'(1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_cnt;
    logic [IW-1:0] r_nidx;
    logic          r_beat;
    logic          r_bar;
    logic [IW-1:0] r_beat_idx;
    logic          r_done;

    state_t        w_state_nxt;
    logic [PW-1:0] w_cnt_nxt;
    logic [IW-1:0] w_nidx_nxt;
    logic          w_beat_nxt;
    logic          w_bar_nxt;
    logic [IW-1:0] w_beat_idx_nxt;
    logic          w_done_nxt;
    logic          w_period_nz;

    assign w_period_nz = (bus.period != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_nidx     <= '0;
            r_beat     <= 1'b0;
            r_bar      <= 1'b0;
            r_beat_idx <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_nidx     <= w_nidx_nxt;
            r_beat     <= w_beat_nxt;
            r_bar      <= w_bar_nxt;
            r_beat_idx <= w_beat_idx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_nidx_nxt     = r_nidx;
        w_beat_nxt     = 1'b0;
        w_bar_nxt      = 1'b0;
        w_beat_idx_nxt = r_beat_idx;
        w_done_nxt     = r_done;

        if (bus.sync) begin
            // Restart overrides pause and one-shot completion alike.
            w_state_nxt    = S_RUN;
            w_done_nxt     = 1'b0;
            w_beat_idx_nxt = '0;
            if (w_period_nz) begin
                w_beat_nxt = 1'b1;
                w_bar_nxt  = 1'b1;
                w_cnt_nxt  = bus.period - c_one;
                w_nidx_nxt = c_idx_one;
            end else begin
                w_cnt_nxt  = '0;
                w_nidx_nxt = '0;
            end
        end else if (bus.en) begin
            case (r_state)
                S_RUN: begin
                    if (w_period_nz) begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - c_one;
                        end else begin
                            w_beat_nxt     = 1'b1;
                            w_beat_idx_nxt = r_nidx;
                            w_bar_nxt      = (r_nidx == '0);
                            w_cnt_nxt      = bus.period - c_one;
                            w_nidx_nxt     = (r_nidx == c_last) ? '0 : r_nidx + c_idx_one;
                            if (bus.oneshot && (r_nidx == c_last)) begin
                                w_state_nxt = S_DONE;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    w_done_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    assign bus.beat     = r_beat;
    assign bus.bar      = r_bar;
    assign bus.beat_idx = r_beat_idx;
    assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_beat_gen.sv
// ============================================================================
// Module   : tb_beat_gen
// Brief    : Directed self-checking bench for beat_gen (PW=22, BEATS=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beat_gen;
    localparam int PW    = 22;
    localparam int BEATS = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    beat_gen_if #(.PW(PW), .BEATS(BEATS)) bif ();

    beat_gen #(.PW(PW), .BEATS(BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bif.en       = 1'b1;
        bif.sync     = 1'b0;
        bif.oneshot  = 1'b0;
        bif.period   = 22'd4;
        tick();
        tick();
        checks++;
        if (bif.beat !== 1'b0 || bif.bar !== 1'b0 || bif.beat_idx !== 2'd0 || bif.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got beat=%b bar=%b idx=%0d done=%b, expected all 0",
                     bif.beat, bif.bar, bif.beat_idx, bif.done);
        end
    endtask

    task automatic test_free_run();
        logic       eb;
        logic       ebar;
        logic [1:0] eidx;
        rst = 1'b1;
        eidx = 2'd0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            eb   = ((c % 4) == 1);
            ebar = (c == 1) || (c == 17);
            if (eb) eidx = 2'((c - 1) / 4);
            checks++;
            if (bif.beat !== eb || bif.bar !== ebar) begin
                errors++;
                $display("FAIL free_run cyc %0d: got beat=%b bar=%b, expected beat=%b bar=%b",
                         c, bif.beat, bif.bar, eb, ebar);
            end
            if (eb) begin
                checks++;
                if (bif.beat_idx !== eidx) begin
                    errors++;
                    $display("FAIL free_run_idx cyc %0d: got %0d expected %0d", c, bif.beat_idx, eidx);
                end
            end
        end
    endtask

    task automatic test_pause();
        logic eb;
        for (int i = 1; i <= 6; i++) begin
            bif.en = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            tick();
            eb = (i == 6);
            checks++;
            if (bif.beat !== eb || bif.bar !== 1'b0) begin
                errors++;
                $display("FAIL pause cyc %0d: got beat=%b bar=%b, expected beat=%b bar=0",
                         i, bif.beat, bif.bar, eb);
            end
        end
        checks++;
        if (bif.beat_idx !== 2'd1) begin
            errors++;
            $display("FAIL pause_idx: got %0d expected 1", bif.beat_idx);
        end
        bif.en = 1'b1;
    endtask

    task automatic test_period_change();
        logic       eb;
        logic [1:0] eidx;
        bif.period = 22'd2;
        for (int i = 1; i <= 8; i++) begin
            tick();
            eb = (i == 4) || (i == 6) || (i == 8);
            checks++;
            if (bif.beat !== eb || bif.bar !== (i == 8)) begin
                errors++;
                $display("FAIL period_change cyc %0d: got beat=%b bar=%b, expected beat=%b bar=%b",
                         i, bif.beat, bif.bar, eb, (i == 8));
            end
            if (eb) begin
                eidx = (i == 4) ? 2'd2 : (i == 6) ? 2'd3 : 2'd0;
                checks++;
                if (bif.beat_idx !== eidx) begin
                    errors++;
                    $display("FAIL period_change_idx cyc %0d: got %0d expected %0d", i, bif.beat_idx, eidx);
                end
            end
        end
    endtask

    task automatic test_oneshot();
        logic       eb;
        logic [1:0] eidx;
        bif.period  = 22'd3;
        bif.oneshot = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            eb = ((i % 3) == 1);
            checks++;
            if (bif.beat !== eb || bif.done !== (i == 10)) begin
                errors++;
                $display("FAIL oneshot cyc %0d: got beat=%b done=%b, expected beat=%b done=%b",
                         i, bif.beat, bif.done, eb, (i == 10));
            end
            if (eb) begin
                eidx = 2'((i - 1) / 3);
                checks++;
                if (bif.beat_idx !== eidx) begin
                    errors++;
                    $display("FAIL oneshot_idx cyc %0d: got %0d expected %0d", i, bif.beat_idx, eidx);
                end
            end
        end
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) bif.oneshot = 1'b0;
            tick();
            checks++;
            if (bif.beat !== 1'b0 || bif.done !== 1'b1 || bif.beat_idx !== 2'd3) begin
                errors++;
                $display("FAIL done_hold cyc %0d: got beat=%b done=%b idx=%0d, expected beat=0 done=1 idx=3",
                         i, bif.beat, bif.done, bif.beat_idx);
            end
        end
        bif.sync = 1'b1;
        tick();
        bif.sync = 1'b0;
        checks++;
        if (bif.beat !== 1'b1 || bif.bar !== 1'b1 || bif.beat_idx !== 2'd0 || bif.done !== 1'b0) begin
            errors++;
            $display("FAIL sync_restart: got beat=%b bar=%b idx=%0d done=%b, expected 1 1 0 0",
                     bif.beat, bif.bar, bif.beat_idx, bif.done);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (bif.beat !== (i == 3)) begin
                errors++;
                $display("FAIL sync_next cyc %0d: got beat=%b expected %b", i, bif.beat, (i == 3));
            end
        end
        checks++;
        if (bif.beat_idx !== 2'd1 || bif.bar !== 1'b0) begin
            errors++;
            $display("FAIL sync_next_idx: got idx=%0d bar=%b, expected idx=1 bar=0", bif.beat_idx, bif.bar);
        end
    endtask

    task automatic test_period_zero();
        logic [1:0] eidx;
        bif.period = 22'd0;
        bif.sync   = 1'b1;
        tick();
        bif.sync = 1'b0;
        checks++;
        if (bif.beat !== 1'b0 || bif.bar !== 1'b0 || bif.beat_idx !== 2'd0) begin
            errors++;
            $display("FAIL sync_period0: got beat=%b bar=%b idx=%0d, expected 0 0 0",
                     bif.beat, bif.bar, bif.beat_idx);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (bif.beat !== 1'b0) begin
                errors++;
                $display("FAIL period0 cyc %0d: got beat=%b expected 0", i, bif.beat);
            end
        end
        bif.period = 22'd1;
        for (int i = 0; i < 6; i++) begin
            tick();
            eidx = 2'(i % 4);
            checks++;
            if (bif.beat !== 1'b1 || bif.beat_idx !== eidx || bif.bar !== (eidx == 2'd0)) begin
                errors++;
                $display("FAIL period1 cyc %0d: got beat=%b idx=%0d bar=%b, expected 1 %0d %b",
                         i, bif.beat, bif.beat_idx, bif.bar, eidx, (eidx == 2'd0));
            end
        end
    endtask

    task automatic test_rst_sync();
        rst      = 1'b0;
        bif.sync = 1'b1;
        tick();
        checks++;
        if (bif.beat !== 1'b0 || bif.bar !== 1'b0 || bif.beat_idx !== 2'd0 || bif.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_over_sync: got beat=%b bar=%b idx=%0d done=%b, expected all 0",
                     bif.beat, bif.bar, bif.beat_idx, bif.done);
        end
        rst        = 1'b1;
        bif.sync   = 1'b0;
        bif.period = 22'd4;
        tick();
        checks++;
        if (bif.beat !== 1'b1 || bif.bar !== 1'b1 || bif.beat_idx !== 2'd0) begin
            errors++;
            $display("FAIL post_rst_beat: got beat=%b bar=%b idx=%0d, expected 1 1 0",
                     bif.beat, bif.bar, bif.beat_idx);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bif.beat !== (i == 4)) begin
                errors++;
                $display("FAIL post_rst_next cyc %0d: got beat=%b expected %b", i, bif.beat, (i == 4));
            end
        end
        checks++;
        if (bif.beat_idx !== 2'd1) begin
            errors++;
            $display("FAIL post_rst_idx: got %0d expected 1", bif.beat_idx);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_free_run();
        test_pause();
        test_period_change();
        test_oneshot();
        test_period_zero();
        test_rst_sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
